// File: rtl/nanci_pkg.sv
// rtl/nanci_pkg.sv - shared widths, field positions, state encoding and snake rule for Nanci mesh drains
package nanci_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  function automatic int word_width(int addr_w, int data_w);
    return addr_w + data_w;
  endfunction

  // A PE word is {addr, data} with data in the LSBs.
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int data_msb(int data_w);
    return data_w - 1;
  endfunction

  function automatic int addr_lsb(int data_w);
    return data_w;
  endfunction

  function automatic int addr_msb(int addr_w, int data_w);
    return addr_w + data_w - 1;
  endfunction

  // Odd rows of a snake-ordered mesh are sorted right-to-left.
  function automatic logic snake_reverse(int row_idx, int snake);
    return (snake != 0) && (row_idx % 2 != 0);
  endfunction

endpackage

// File: rtl/pe_order_checker.sv
// rtl/pe_order_checker.sv - sticky non-decreasing monitor over a stream of accepted data values
module pe_order_checker #(
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_err
);

  logic [DATA_WIDTH-1:0] prev_data;
  logic                  have_prev;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      prev_data <= '0;
      have_prev <= 1'b0;
      o_err     <= 1'b0;
    end else if (i_accept) begin
      // The first word of a drain has nothing to be compared against.
      if (have_prev && (i_data < prev_data)) begin
        o_err <= 1'b1;
      end
      prev_data <= i_data;
      have_prev <= 1'b1;
    end
  end

endmodule

// File: rtl/pe_row_drain.sv
// rtl/pe_row_drain.sv - snapshots one mesh row of PE words and streams them out in snake order
module pe_row_drain
  import nanci_pkg::*;
#(
  parameter int ROW_LEN    = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int ROW_IDX    = 0,
  parameter int SNAKE      = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_sort_done,
  input  logic [ROW_LEN*(ADDR_WIDTH+DATA_WIDTH)-1:0]  i_row_pe,
  output logic                                        o_valid,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]            o_word,
  input  logic                                        i_ready,
  output logic                                        o_last,
  output logic                                        o_busy,
  output logic                                        o_order_err,
  output logic                                        o_overrun
);

  localparam int WW       = word_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int IW       = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int DATA_MSB = data_msb(DATA_WIDTH);
  localparam int DATA_LSB = data_lsb();
  localparam logic REVERSE = snake_reverse(ROW_IDX, SNAKE);
  localparam logic [IW-1:0] FIRST_IDX = REVERSE ? IW'(ROW_LEN - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX  = REVERSE ? '0 : IW'(ROW_LEN - 1);

  logic [0:0]    state;
  logic [IW-1:0] idx;
  logic [WW-1:0] row_buf [ROW_LEN];
  logic          start;
  logic          accept;

  assign start   = (state == ST_IDLE) && i_sort_done;
  assign o_valid = (state == ST_DRAIN);
  assign o_busy  = o_valid;
  assign o_last  = o_valid && (idx == LAST_IDX);
  // Output comes only from the snapshot, never from the live PE buses.
  assign o_word  = o_valid ? row_buf[idx] : '0;
  assign accept  = o_valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      o_overrun <= 1'b0;
      for (int j = 0; j < ROW_LEN; j++) begin
        row_buf[j] <= '0;
      end
    end else if (state == ST_IDLE) begin
      if (i_sort_done) begin
        for (int j = 0; j < ROW_LEN; j++) begin
          row_buf[j] <= i_row_pe[j*WW +: WW];
        end
        idx   <= FIRST_IDX;
        state <= ST_DRAIN;
      end
    end else begin
      // A new sort result while draining is dropped, including on the final beat.
      if (i_sort_done) begin
        o_overrun <= 1'b1;
      end
      if (accept) begin
        if (o_last) begin
          state <= ST_IDLE;
        end else if (REVERSE) begin
          idx <= idx - IW'(1);
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  pe_order_checker #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_order_checker (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (start),
    .i_accept (accept),
    .i_data   (o_word[DATA_MSB:DATA_LSB]),
    .o_err    (o_order_err)
  );

endmodule

// File: tb/tb_pe_row_drain.sv
// tb/tb_pe_row_drain.sv - randomized self-checking bench for pe_row_drain on an even and an odd row
module tb_pe_row_drain;

  localparam int RL = 4;
  localparam int AW = 3;
  localparam int DW = 3;
  localparam int WW = AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sd0, sd1, ready;
  logic [RL*WW-1:0] row_pe;

  logic          v0, l0, b0, oe0, ov0;
  logic          v1, l1, b1, oe1, ov1;
  logic [WW-1:0] w0, w1;

  logic          v, l, b, oe, ov;
  logic [WW-1:0] wd;
  int            cur_row;

  logic [WW-1:0] cur_w [RL];
  logic [WW-1:0] exp_q [RL];
  bit            ov_model [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_row_drain #(.ROW_LEN(RL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW_IDX(0), .SNAKE(1)) dut0 (
    .clk(clk), .rst(rst), .i_sort_done(sd0), .i_row_pe(row_pe),
    .o_valid(v0), .o_word(w0), .i_ready(ready), .o_last(l0),
    .o_busy(b0), .o_order_err(oe0), .o_overrun(ov0)
  );

  pe_row_drain #(.ROW_LEN(RL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW_IDX(1), .SNAKE(1)) dut1 (
    .clk(clk), .rst(rst), .i_sort_done(sd1), .i_row_pe(row_pe),
    .o_valid(v1), .o_word(w1), .i_ready(ready), .o_last(l1),
    .o_busy(b1), .o_order_err(oe1), .o_overrun(ov1)
  );

  always_comb begin
    v = v0; l = l0; b = b0; oe = oe0; ov = ov0; wd = w0;
    if (cur_row == 1) begin
      v = v1; l = l1; b = b1; oe = oe1; ov = ov1; wd = w1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Any descent among the first n emitted words is an order error.
  function automatic bit prefix_err(int n);
    bit e = 1'b0;
    for (int i = 1; i < n; i++) begin
      if (exp_q[i][DW-1:0] < exp_q[i-1][DW-1:0]) e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [RL*WW-1:0] pack_row();
    logic [RL*WW-1:0] r;
    for (int i = 0; i < RL; i++) r[i*WW +: WW] = cur_w[i];
    return r;
  endfunction

  task automatic set_sd(input int row, input logic val);
    if (row == 1) sd1 = val;
    else          sd0 = val;
  endtask

  // rdy_mode: 0 always ready, 1 toggle starting high, 2 random
  task automatic drain(input int row, input int rdy_mode, input bit inject_ov, input bit abort);
    int  k   = 0;
    int  cyc = 0;
    bit  ov_done = 1'b0;
    for (int i = 0; i < RL; i++) exp_q[i] = (row % 2 == 1) ? cur_w[RL-1-i] : cur_w[i];
    cur_row = row;
    @(negedge clk);
    row_pe = pack_row();
    ready  = 1'b0;
    set_sd(row, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_sd(row, 1'b0);
    check("latency_valid", 32'(v), 32'd1);
    while (k < RL && cyc < 40) begin
      check("word", 32'(wd), 32'(exp_q[k]));
      check("last", 32'(l), 32'(k == RL - 1));
      check("busy", 32'(b), 32'd1);
      check("order_err", 32'(oe), 32'(prefix_err(k)));
      check("overrun", 32'(ov), 32'(ov_model[row]));
      if (inject_ov && k == 1 && !ov_done) begin
        ov_done = 1'b1;
        ov_model[row] = 1'b1;
        row_pe = ~row_pe;
        set_sd(row, 1'b1);
      end
      case (rdy_mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      if (ready) k++;
      cyc++;
      @(negedge clk);
      set_sd(row, 1'b0);
      ready = 1'b0;
      if (abort && k == 2) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ov_model[0] = 1'b0;
        ov_model[1] = 1'b0;
        check("abort_valid", 32'(v), 32'd0);
        check("abort_busy", 32'(b), 32'd0);
        check("abort_last", 32'(l), 32'd0);
        check("abort_order_err", 32'(oe), 32'd0);
        check("abort_overrun", 32'(ov), 32'd0);
        return;
      end
    end
    if (k < RL) check("drain_timeout", 32'(k), 32'(RL));
    check("end_valid", 32'(v), 32'd0);
    check("end_busy", 32'(b), 32'd0);
    check("end_order_err", 32'(oe), 32'(prefix_err(RL)));
    check("end_overrun", 32'(ov), 32'(ov_model[row]));
  endtask

  task automatic load_words(input logic [WW-1:0] a, input logic [WW-1:0] bb,
                            input logic [WW-1:0] c, input logic [WW-1:0] d);
    cur_w[0] = a; cur_w[1] = bb; cur_w[2] = c; cur_w[3] = d;
  endtask

  initial begin
    rst = 1'b1; sd0 = 1'b0; sd1 = 1'b0; ready = 1'b0; row_pe = '0; cur_row = 0;
    ov_model[0] = 1'b0; ov_model[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid0", 32'(v0), 32'd0);
    check("rst_word0", 32'(w0), 32'd0);
    check("rst_flags0", 32'({l0, b0, oe0, ov0}), 32'd0);
    check("rst_valid1", 32'(v1), 32'd0);
    check("rst_flags1", 32'({l1, b1, oe1, ov1}), 32'd0);

    load_words(6'b000001, 6'b001011, 6'b010101, 6'b011110);
    drain(0, 0, 1'b0, 1'b0);

    load_words(6'b000110, 6'b001101, 6'b010011, 6'b011001);
    drain(1, 0, 1'b0, 1'b0);

    load_words(6'b000001, 6'b001011, 6'b010101, 6'b011110);
    drain(0, 0, 1'b1, 1'b0);

    load_words(6'b000010, 6'b001100, 6'b010011, 6'b011111);
    drain(0, 1, 1'b0, 1'b0);

    load_words(6'b000001, 6'b001011, 6'b010101, 6'b011110);
    drain(0, 0, 1'b0, 1'b1);
    drain(0, 0, 1'b0, 1'b0);

    load_words(6'b000011, 6'b001011, 6'b010011, 6'b011011);
    drain(0, 2, 1'b0, 1'b0);
    drain(1, 2, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < RL; i++) cur_w[i] = WW'($urandom);
      drain(int'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_row_drain.md
Name: pe_row_drain

Overview:
- Downstream consumer of one row of PE outputs in the Nanci sorting mesh.
- On a sort-complete pulse, snapshots the ROW_LEN {addr,data} words driven on the PEs' o_PE buses.
- Streams the words out one per beat over a valid/ready interface, in snake order: odd rows are reversed so output is globally ascending.
- Checks that emitted data is non-decreasing and flags violations; this serves as an on-chip sortedness monitor for mesh runs.

Parameters:
- ROW_LEN, 4: number of PEs in the row (SQRT_N); must be ≥1.
- ADDR_WIDTH, 3: address field width of each PE word.
- DATA_WIDTH, 3: data field width of each PE word.
- ROW_IDX, 0: row index of this row in the mesh.
- SNAKE, 1: when 1 and ROW_IDX is odd, words are emitted from highest index to lowest; otherwise lowest to highest.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_sort_done  in  1  one-cycle pulse: row outputs are final and stable this cycle.
- i_row_pe  in  ROW_LEN*(ADDR_WIDTH+DATA_WIDTH)  concatenated PE o_PE words; PE j occupies slice j (PE 0 in LSBs); word = {addr, data} with data in LSBs.
- o_valid  out  1  output word valid.
- o_word  out  ADDR_WIDTH+DATA_WIDTH  current output word.
- i_ready  in  1  consumer accepts o_word when o_valid && i_ready.
- o_last  out  1  high with o_valid on the final word of the row.
- o_busy  out  1  high while in DRAIN.
- o_order_err  out  1  sticky: an accepted word's data was less than the previous accepted word's data in the same drain.
- o_overrun  out  1  sticky: i_sort_done arrived while busy.

Behaviour:
- Reset: all outputs 0, state IDLE, buffer and index cleared. Reset asserted mid-drain aborts the drain; the next cycle is IDLE with all outputs 0.
- IDLE, i_sort_done=1:
  - capture all ROW_LEN words into the buffer;
  - load the index with 0, or ROW_LEN-1 if reversed;
  - clear o_order_err and the previous-data register;
  - go to DRAIN.
- Latency: o_valid rises the cycle after the i_sort_done edge (1 cycle).
- DRAIN:
  - o_valid=1; o_word=buffer[index], registered, with no combinational path from i_row_pe.
  - o_last=1 when the index is at the final position.
  - o_word is held stable until accepted.
- Acceptance (o_valid && i_ready):
  - if this is not the first word and data < prev_data, set o_order_err the next cycle;
  - store prev_data;
  - step the index ±1.
  - If o_last, go to IDLE the next cycle; o_valid drops with no bubble word.
- Equal data values are not an error. The addr field is not checked.
- i_ready low stalls indefinitely. No timeout.
- i_sort_done in DRAIN is ignored (the buffer is not overwritten) and sets o_overrun. Only reset clears o_overrun.
- i_sort_done in the same cycle as the final acceptance counts as overrun and is not captured.
- ROW_LEN=1: a single beat with o_last=1. o_order_err can never set.
- Index width is clog2(ROW_LEN), minimum 1. No wrap-around: the index never steps past the final position.

Decomposition:
- Shared package nanci_pkg:
  - word-width function (ADDR_WIDTH+DATA_WIDTH);
  - field extract helpers for addr and data;
  - state encoding IDLE/DRAIN;
  - function for the snake-direction rule (row odd && SNAKE).
- One natural sub-module: pe_order_checker (prev_data register + compare + sticky flag), reusable for column drains.

Test Plan:
All scenarios use ROW_LEN=4, ADDR_WIDTH=3, DATA_WIDTH=3.
- Forward: ROW_IDX=0, i_row_pe words PE0..3 = 000001, 001011, 010101, 011110, pulse i_sort_done, i_ready=1 -> o_valid high from the next cycle; words 000001, 001011, 010101, 011110 on 4 consecutive cycles; o_last on the 4th; o_order_err=0; then IDLE.
- Snake reverse: ROW_IDX=1, SNAKE=1, PE0..3 = 000110, 001101, 010011, 011001 -> emitted 011001, 010011, 001101, 000110; o_order_err=0.
- Order error plus backpressure: ROW_IDX=0, PE0..3 = 000010, 001100, 010011, 011111; i_ready toggles 1,0,1,0,… -> each word held during stalls; o_order_err rises the cycle after 010011 is accepted and stays high; all 4 words emitted.
- Overrun: pulse i_sort_done again during the 2nd word with different i_row_pe -> the original words still emitted; o_overrun=1 and sticky until rst.
- Reset mid-drain: assert rst for 1 cycle after the 2nd word -> next cycle o_valid=o_busy=o_last=o_order_err=o_overrun=0. A fresh i_sort_done then drains all 4 words correctly from the first.
- Equal data: PE0..3 data 011, 011, 011, 011 -> no o_order_err.
